cache_controller_wb: RTL and testbench
======================================

# cache_controller_wb

Direct-mapped, write-back, write-allocate cache controller sitting between the CPU load/store port and the 128-bit-block write-back main memory. It serves 32-bit word accesses from a 4-line cache, hits in two cycles, and on a miss writes back a dirty victim block and then fetches the missing block. It holds each memory transaction for a fixed number of cycles because the memory array itself is untimed.

## Interface
- `MEM_LATENCY`, default 4: cycles each memory transaction is held; range 1..15.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: request valid; sampled in IDLE.
- `cpu_rw` in 1: 1 = write, 0 = read.
- `cpu_addr` in 10: byte address. Tag [9:6], index [5:4], word [3:2]; [1:0] ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data, registered; valid while `cpu_ready` is high.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_read_write` out 1: 1 = write, 0 = read.
- `mem_address` out 10: block address, always `{tag,index,4'b0000}`.
- `mem_write_data` out 128: victim block; word 0 in [31:0].
- `mem_read_data` in 128: fetched block, same word order.

## Operation
- Per line: valid, dirty, 4-bit tag, 128-bit data.
- The request is latched on acceptance. CPU inputs need not be held afterwards.
- States and transitions:
  - IDLE: if `cpu_req`, latch the request and go to COMPARE.
  - COMPARE, hit (valid and tag match):
    - Read: return the selected word.
    - Write: replace the selected word and set dirty.
    - Then set `cpu_ready` and go to IDLE.
  - COMPARE, miss: go to WRITEBACK if the victim is valid and dirty, otherwise go to ALLOCATE.
  - WRITEBACK: drive `mem_read_write`=1, the victim's address and the victim's data for MEM_LATENCY cycles, then go to ALLOCATE.
  - ALLOCATE: drive `mem_read_write`=0 and the request's block address for MEM_LATENCY cycles. On the last cycle, capture `mem_read_data` into the line and set valid=1, dirty=0, tag=request tag. Then go to COMPARE, which now hits.
- Latency counter: 4-bit, loaded with MEM_LATENCY-1 on entry to WRITEBACK or ALLOCATE, and decrements to 0.
- Outside WRITEBACK, `mem_read_write` is 0.
- Back-to-back requests: `cpu_req` high in the same cycle as `cpu_ready` is accepted as a new request.
- Reset has priority over everything:
  - Next cycle: state IDLE, all valid and dirty bits cleared, `cpu_ready`=0, `cpu_rdata`=0, `mem_read_write`=0, `mem_address`=0, `mem_write_data`=0.
  - Reset during WRITEBACK or ALLOCATE abandons the transaction. Dirty data is lost.

## Timing
- Request accepted at edge k. COMPARE occupies cycle k+1.
- Hit: `cpu_ready` is high in cycle k+2.
- Clean miss: ready at cycle k+MEM_LATENCY+3.
- Dirty miss: ready at cycle k+2·MEM_LATENCY+3.
- Memory outputs are registered and stable for the full MEM_LATENCY window. Read data is sampled at the window's final edge.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `hit_count[15:0]` and `miss_count[15:0]`.
  - Counting happens on the first COMPARE of each request only; the post-allocate re-compare is not counted.
  - Counters saturate at 0xFFFF and clear on reset.
- Undefined: no counters and no extra ports.

## Structure
- `cache_pkg` holds:
  - State enum {IDLE, COMPARE, WRITEBACK, ALLOCATE}.
  - TAG_W=4, INDEX_W=2, WORD_W=2, BLOCK_W=128.
  - Address field slice helpers.
- Sub-module `cache_line_array`: tag/valid/dirty/data storage with one read port and a write port supporting either word-granular or whole-line writes.

## Test plan
All cases use MEM_LATENCY=4. Word n of block B means `mem_read_data[32n+31:32n]`, with memory block 0x040 preloaded as words {0x1111_0000, 0x1111_0001, 0x1111_0002, 0x1111_0003}.
- Reset, then read 0x044:
  - Clean miss; ALLOCATE drives `mem_address`=0x040 for 4 cycles.
  - `cpu_ready` at k+7 with `cpu_rdata`=0x1111_0001.
- Read 0x04C after the above: hit, `cpu_ready` at k+2, `cpu_rdata`=0x1111_0003, `mem_read_write` stays 0.
- Write 0x048 data 0xDEADBEEF (hit, line dirty), then read 0x148:
  - WRITEBACK to 0x040 with `mem_write_data[95:64]`=0xDEADBEEF for 4 cycles.
  - Then ALLOCATE from 0x140.
  - Ready at k+11.
- Reset during the 2nd ALLOCATE cycle:
  - Next cycle `mem_read_write`=0 and `cpu_ready`=0.
  - A repeat read of 0x044 misses again (7 cycles).
- `cpu_req` held high with alternating reads 0x044 and 0x0C4 (same index, different tag): every access misses, and the second is accepted in the first's ready cycle.
- `CACHE_STATS_EN`, after cases 1–3: `hit_count`=2, `miss_count`=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, widths and address-field helpers for the write-back cache controller.
package cache_pkg;

    localparam int ADDR_W    = 10;
    localparam int WADDR_W   = ADDR_W - 2;   // word address: byte offset dropped
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 4;
    localparam int INDEX_W   = 2;
    localparam int WORD_W    = 2;
    localparam int BLOCK_W   = 128;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [WADDR_W-1:0] waddr);
        return waddr[WADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [WADDR_W-1:0] waddr);
        return waddr[WORD_W +: INDEX_W];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [WADDR_W-1:0] waddr);
        return waddr[WORD_W-1:0];
    endfunction

    // Block-aligned byte address of a line.
    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [INDEX_W-1:0] index);
        return {tag, index, 4'b0000};
    endfunction

    // Word n of a block lives in bits [32n+31:32n].
    function automatic logic [DATA_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                     input logic [WORD_W-1:0] w);
        return blk[{w, 5'b00000} +: DATA_W];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: one read port,
// one write port that either stores a single word (marking the line dirty)
// or refills a whole line (valid, clean).
module cache_line_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               word_we,
    input  logic [WORD_W-1:0]  word_sel,
    input  logic [DATA_W-1:0]  word_data,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   line_tag,
    input  logic [BLOCK_W-1:0] line_data
);

    logic [NUM_LINES-1:0] valid_all;
    logic [NUM_LINES-1:0] dirty_all;
    logic [TAG_W-1:0]     tag_all  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_all [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic               sel;
            logic               valid_q, valid_d;
            logic               dirty_q, dirty_d;
            logic [TAG_W-1:0]   tag_q, tag_d;
            logic [BLOCK_W-1:0] data_q, data_d;

            assign sel = (wr_index == INDEX_W'(gi));

            // Line update: a refill replaces everything, a store patches one word
            always_comb begin
                valid_d = valid_q;
                dirty_d = dirty_q;
                tag_d   = tag_q;
                data_d  = data_q;
                if (sel && line_we) begin
                    valid_d = 1'b1;
                    dirty_d = 1'b0;
                    tag_d   = line_tag;
                    data_d  = line_data;
                end else if (sel && word_we) begin
                    dirty_d = 1'b1;
                    data_d[{word_sel, 5'b00000} +: DATA_W] = word_data;
                end
            end

            // Only valid/dirty need a reset; tag and data are qualified by valid
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    dirty_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    dirty_q <= dirty_d;
                end
                tag_q  <= tag_d;
                data_q <= data_d;
            end

            assign valid_all[gi] = valid_q;
            assign dirty_all[gi] = dirty_q;
            assign tag_all[gi]   = tag_q;
            assign data_all[gi]  = data_q;
        end
    endgenerate

    assign rd_valid = valid_all[rd_index];
    assign rd_dirty = dirty_all[rd_index];
    assign rd_tag   = tag_all[rd_index];
    assign rd_data  = data_all[rd_index];

endmodule

// File: rtl/cache_controller_wb.sv
// Direct-mapped, write-back, write-allocate cache controller (4 lines of
// 128-bit blocks) between a 32-bit CPU port and a block-wide memory.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller_wb
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_rw,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               mem_read_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_write_data,
    input  logic [BLOCK_W-1:0] mem_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t               state_q, state_d;
    logic [WADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                 req_rw_q, req_rw_d;
    logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic                 mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_data;
    logic [INDEX_W-1:0]   req_index;
    logic                 hit, cnt_done, word_we, line_we;
    logic                 unused_byte_offset;

    // Accesses are word-granular; the byte offset carries no information.
    assign unused_byte_offset = ^cpu_addr[1:0];

    assign req_index = addr_index(req_addr_q);
    assign hit       = rd_valid && (rd_tag == addr_tag(req_addr_q));
    assign cnt_done  = (cnt_q == '0);

    cache_line_array u_lines (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (req_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (req_index),
        .word_we   (word_we),
        .word_sel  (addr_word(req_addr_q)),
        .word_data (req_wdata_q),
        .line_we   (line_we),
        .line_tag  (addr_tag(req_addr_q)),
        .line_data (mem_read_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cpu_req) state_d = COMPARE;
            COMPARE: begin
                if (hit)                      state_d = IDLE;
                else if (rd_valid && rd_dirty) state_d = WRITEBACK;
                else                          state_d = ALLOCATE;
            end
            WRITEBACK: if (cnt_done) state_d = ALLOCATE;
            ALLOCATE:  if (cnt_done) state_d = COMPARE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs and datapath: memory signals are set up from the next state so
    // they are registered and stable for the whole latency window
    always_comb begin
        req_addr_d  = req_addr_q;
        req_rw_d    = req_rw_q;
        req_wdata_d = req_wdata_q;
        if (state_q == IDLE && cpu_req) begin
            req_addr_d  = cpu_addr[ADDR_W-1:2];
            req_rw_d    = cpu_rw;
            req_wdata_d = cpu_wdata;
        end

        cnt_d = cnt_q;
        if ((state_d == WRITEBACK || state_d == ALLOCATE) && state_d != state_q)
            cnt_d = LAT_LOAD;
        else if (!cnt_done)
            cnt_d = cnt_q - 1'b1;

        word_we     = (state_q == COMPARE) && hit && req_rw_q;
        line_we     = (state_q == ALLOCATE) && cnt_done;
        cpu_ready_d = (state_q == COMPARE) && hit;
        cpu_rdata_d = cpu_rdata_q;
        if (state_q == COMPARE && hit && !req_rw_q)
            cpu_rdata_d = block_word(rd_data, addr_word(req_addr_q));

        mem_rw_d    = (state_d == WRITEBACK);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == WRITEBACK) begin
            mem_addr_d  = block_addr(rd_tag, req_index);
            mem_wdata_d = rd_data;
        end else if (state_d == ALLOCATE) begin
            mem_addr_d  = block_addr(addr_tag(req_addr_q), req_index);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_q  <= '0;
            req_rw_q    <= 1'b0;
            req_wdata_q <= '0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            req_addr_q  <= req_addr_d;
            req_rw_q    <= req_rw_d;
            req_wdata_q <= req_wdata_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign mem_read_write = mem_rw_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic        refill_q, refill_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // Count the first COMPARE of a request only; the re-compare after a
    // refill is recognised by having come straight from ALLOCATE
    always_comb begin
        refill_d     = (state_q == ALLOCATE);
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == COMPARE && !refill_q) begin
            if (hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            refill_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller_wb.sv
// Self-checking bench for cache_controller_wb (MEM_LATENCY=4) with an
// untimed block memory model and a request scoreboard.
`timescale 1ns/1ps
module tb_cache_controller_wb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_rw = 1'b0;
    logic [9:0]   cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_read_write;
    logic [9:0]   mem_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    logic [127:0] mem [64];
    logic         mem_init = 1'b1;
    int           n_cmp = 0;
    int           n_fail = 0;
    int           edge_cnt = 0;
    int           wb_cycles = 0;
    logic [9:0]   wb_addr_seen = '0;
    logic [127:0] wb_data_seen = '0;

    int           exp_edge_q [$];
    logic [31:0]  exp_data_q [$];
    bit           exp_read_q [$];

    cache_controller_wb #(.MEM_LATENCY(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_rw         (cpu_rw),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Initial memory content: block 4 (0x040) holds 0x1111_000n, others a tag pattern
    function automatic logic [31:0] pat(input int blk, input int w);
        if (blk == 4) return 32'h1111_0000 + 32'(w);
        return 32'hA000_0000 | (32'(blk) << 8) | 32'(w);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int b = 0; b < 64; b++) mem[b] <= {pat(b, 3), pat(b, 2), pat(b, 1), pat(b, 0)};
        end else if (mem_read_write) begin
            mem[mem_address[9:4]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_address[9:4]];

    // Record write-back activity for the tests to inspect
    always @(negedge clk) begin
        if (mem_read_write === 1'b1) begin
            wb_cycles    = wb_cycles + 1;
            wb_addr_seen = mem_address;
            wb_data_seen = mem_write_data;
        end
    end

    // Drive one request (DUT assumed IDLE), push its expectation, then scramble inputs
    task automatic issue(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                         input int lat, input logic [31:0] exp_d);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        exp_edge_q.push_back(edge_cnt + lat - 1);
        exp_data_q.push_back(exp_d);
        exp_read_q.push_back(!rw);
        cpu_req = 1'b0; cpu_rw = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = $urandom;
    endtask

    task automatic wait_ready(output int e, output logic [31:0] d, output bit to);
        to = 1'b1; e = -1; d = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                e = edge_cnt; d = cpu_rdata; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_cmp++; if (mem_read_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rw: got %b want 0", mem_read_write); end
        n_cmp++; if (mem_address !== 10'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_address); end
        n_cmp++; if (mem_write_data !== 128'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_write_data); end
        mem_init = 1'b0;
        reset = 1'b0;
    endtask

    // Run a table of requests back to back and check latency and read data of each
    task automatic run_table(input string name, input int n, input logic rws [8],
                             input logic [9:0] addrs [8], input logic [31:0] wds [8],
                             input int lats [8], input logic [31:0] exps [8]);
        int e; logic [31:0] d; bit to; int ee; logic [31:0] ed; bit er;
        for (int i = 0; i < n; i++) begin
            issue(rws[i], addrs[i], wds[i], lats[i], exps[i]);
            wait_ready(e, d, to);
            ee = exp_edge_q.pop_front(); ed = exp_data_q.pop_front(); er = exp_read_q.pop_front();
            $display("txn %s[%0d] rw=%0d addr=%h ready_edge=%0d rdata=%h", name, i, rws[i], addrs[i], e, d);
            n_cmp++;
            if (to || e !== ee) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: ready at edge %0d (timeout=%0d), required edge %0d", name, i, e, to, ee);
            end
            if (er) begin
                n_cmp++;
                if (d !== ed) begin
                    n_fail++;
                    $display("FAIL %s_rdata[%0d]: got %h required %h", name, i, d, ed);
                end
            end
        end
    endtask

    task automatic test_clean_miss();
        logic rws [8] = '{default: 1'b0};
        logic [9:0] addrs [8] = '{default: '0};
        logic [31:0] wds [8] = '{default: '0};
        int lats [8] = '{default: 0};
        logic [31:0] exps [8] = '{default: '0};
        addrs[0] = 10'h044; lats[0] = 7; exps[0] = 32'h1111_0001;
        run_table("clean_miss", 1, rws, addrs, wds, lats, exps);
    endtask

    task automatic test_hit();
        logic rws [8] = '{default: 1'b0};
        logic [9:0] addrs [8] = '{default: '0};
        logic [31:0] wds [8] = '{default: '0};
        int lats [8] = '{default: 0};
        logic [31:0] exps [8] = '{default: '0};
        int wb_before;
        wb_before = wb_cycles;
        addrs[0] = 10'h04C; lats[0] = 2; exps[0] = 32'h1111_0003;
        run_table("hit", 1, rws, addrs, wds, lats, exps);
        n_cmp++;
        if (wb_cycles !== wb_before) begin
            n_fail++; $display("FAIL hit_no_writeback: %0d write cycles, required 0", wb_cycles - wb_before);
        end
    endtask

    task automatic test_dirty_miss();
        logic rws [8] = '{default: 1'b0};
        logic [9:0] addrs [8] = '{default: '0};
        logic [31:0] wds [8] = '{default: '0};
        int lats [8] = '{default: 0};
        logic [31:0] exps [8] = '{default: '0};
        int wb_before;
        wb_before = wb_cycles;
        rws[0] = 1'b1; addrs[0] = 10'h048; wds[0] = 32'hDEAD_BEEF; lats[0] = 2;
        addrs[1] = 10'h148; lats[1] = 11; exps[1] = pat(8'h14, 2);
        run_table("dirty_miss", 2, rws, addrs, wds, lats, exps);
        n_cmp++;
        if (wb_cycles - wb_before !== 4) begin
            n_fail++; $display("FAIL wb_cycles: got %0d required 4", wb_cycles - wb_before);
        end
        n_cmp++;
        if (wb_addr_seen !== 10'h040) begin
            n_fail++; $display("FAIL wb_addr: got %h required 040", wb_addr_seen);
        end
        n_cmp++;
        if (wb_data_seen[95:64] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wb_word2: got %h required deadbeef", wb_data_seen[95:64]);
        end
        n_cmp++;
        if (wb_data_seen[63:32] !== 32'h1111_0001) begin
            n_fail++; $display("FAIL wb_word1: got %h required 11110001", wb_data_seen[63:32]);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        n_cmp++;
        if (hit_count !== 16'd2) begin n_fail++; $display("FAIL hit_count: got %0d required 2", hit_count); end
        n_cmp++;
        if (miss_count !== 16'd2) begin n_fail++; $display("FAIL miss_count: got %0d required 2", miss_count); end
    endtask
`endif

    task automatic test_reset_mid_alloc();
        logic rws [8] = '{default: 1'b0};
        logic [9:0] addrs [8] = '{default: '0};
        logic [31:0] wds [8] = '{default: '0};
        int lats [8] = '{default: 0};
        logic [31:0] exps [8] = '{default: '0};
        int dump_e; logic [31:0] dump_d; bit dump_r;
        issue(1'b0, 10'h044, 32'h0, 7, 32'h1111_0001);
        repeat (3) @(negedge clk);          // COMPARE, ALLOCATE 1, ALLOCATE 2
        reset = 1'b1;
        @(negedge clk);
        $display("txn reset_mid_alloc addr=044 abandoned at edge %0d", edge_cnt);
        n_cmp++;
        if (mem_read_write !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_mem_rw: got %b want 0", mem_read_write); end
        n_cmp++;
        if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_alloc_ready: got %b want 0", cpu_ready); end
        n_cmp++;
        if (mem_address !== 10'h0) begin n_fail++; $display("FAIL rst_alloc_mem_addr: got %h want 0", mem_address); end
        dump_e = exp_edge_q.pop_front(); dump_d = exp_data_q.pop_front(); dump_r = exp_read_q.pop_front();
        reset = 1'b0;
        addrs[0] = 10'h044; lats[0] = 7; exps[0] = 32'h1111_0001;
        run_table("after_reset", 1, rws, addrs, wds, lats, exps);
    endtask

    task automatic test_back_to_back();
        int e; logic [31:0] d; bit to; int ee; logic [31:0] ed; bit er;
        cpu_req = 1'b1; cpu_rw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = (i % 2 == 0) ? 10'h0C4 : 10'h044;
            @(posedge clk); #1;
            exp_edge_q.push_back(edge_cnt + 6);
            exp_data_q.push_back((i % 2 == 0) ? pat(8'h0C, 1) : 32'h1111_0001);
            exp_read_q.push_back(1'b1);
            wait_ready(e, d, to);
            ee = exp_edge_q.pop_front(); ed = exp_data_q.pop_front(); er = exp_read_q.pop_front();
            $display("txn b2b[%0d] addr=%h ready_edge=%0d rdata=%h", i, cpu_addr, e, d);
            n_cmp++;
            if (to || e !== ee) begin
                n_fail++; $display("FAIL b2b_latency[%0d]: ready at edge %0d (timeout=%0d), required edge %0d", i, e, to, ee);
            end
            if (er) begin
                n_cmp++;
                if (d !== ed) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h required %h", i, d, ed); end
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_write_allocate();
        logic rws [8] = '{default: 1'b0};
        logic [9:0] addrs [8] = '{default: '0};
        logic [31:0] wds [8] = '{default: '0};
        int lats [8] = '{default: 0};
        logic [31:0] exps [8] = '{default: '0};
        rws[0] = 1'b1; addrs[0] = 10'h2A8; wds[0] = 32'hCAFE_F00D; lats[0] = 7;
        addrs[1] = 10'h2A8; lats[1] = 2;  exps[1] = 32'hCAFE_F00D;
        addrs[2] = 10'h2A0; lats[2] = 2;  exps[2] = pat(8'h2A, 0);
        addrs[3] = 10'h1A0; lats[3] = 11; exps[3] = pat(8'h1A, 0);
        addrs[4] = 10'h2A8; lats[4] = 7;  exps[4] = 32'hCAFE_F00D;
        run_table("write_alloc", 5, rws, addrs, wds, lats, exps);
        n_cmp++;
        if (wb_addr_seen !== 10'h2A0) begin
            n_fail++; $display("FAIL wa_wb_addr: got %h required 2a0", wb_addr_seen);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_hit();
        test_dirty_miss();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_alloc();
        test_back_to_back();
        test_write_allocate();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
